cpu_control_unit: RTL and testbench

- Synthesizable fetch/decode/execute sequencer for the 8-bit processor.
- Drives the program counter and instruction-register enable. Sequences register-file reads and writes, ALU operand/opcode presentation, flag write-back and branches.
- Sits between inst_reg (upstream, supplies ir_data) and registers/alu (downstream). Replaces the bench-driven sequencing with a clocked FSM.

---
 rtl/cpu_control_unit_if.sv | 38 +++
 rtl/cpu_control_unit.sv | 206 ++++++++++++++++++++
 tb/tb_cpu_control_unit.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_control_unit_if.sv
`default_nettype none
// ============================================================================
// cpu_control_unit_if : fetch, register-file and ALU bus of the control unit
// Revision 1.0 - initial release
// ============================================================================
interface cpu_control_unit_if #(
   parameter int PC_W = 8
);
   logic [PC_W-1:0] pc_out;
   logic            ir_en;
   logic [15:0]     ir_data;
   logic [2:0]      rf_addr;
   logic            rf_rd;
   logic            rf_wr;
   logic [7:0]      rf_din;
   logic [7:0]      rf_dout;
   logic [2:0]      alu_op;
   logic [7:0]      alu_a;
   logic [7:0]      alu_b;
   logic [7:0]      alu_out;
   logic            alu_cy;
   logic            alu_zero;
   logic            instr_done;
   logic            halted;

   modport master (
      output pc_out, ir_en, rf_addr, rf_rd, rf_wr, rf_din,
             alu_op, alu_a, alu_b, instr_done, halted,
      input  ir_data, rf_dout, alu_out, alu_cy, alu_zero
   );

   modport slave (
      input  pc_out, ir_en, rf_addr, rf_rd, rf_wr, rf_din,
             alu_op, alu_a, alu_b, instr_done, halted,
      output ir_data, rf_dout, alu_out, alu_cy, alu_zero
   );
endinterface
`default_nettype wire

// File: rtl/cpu_control_unit.sv
`default_nettype none
// ============================================================================
// cpu_control_unit : fetch/decode/execute sequencer for the 8-bit processor
// Revision 1.0 - initial release
// ============================================================================
module cpu_control_unit #(
   parameter int         PC_W      = 8,
   parameter logic [2:0] FLAG_ADDR = 3'b111
) (
   input logic                clk,
   input logic                rst_n,
   cpu_control_unit_if.master bus
);
   localparam logic [3:0] c_op_inv  = 4'b0101;
   localparam logic [3:0] c_op_load = 4'b1000;
   localparam logic [3:0] c_op_jz   = 4'b1001;
   localparam logic [3:0] c_op_hlt  = 4'b1100;
   localparam logic [3:0] c_op_jc   = 4'b1101;
   localparam logic [3:0] c_op_jnz  = 4'b1110;
   localparam logic [3:0] c_op_jmp  = 4'b1111;
   localparam logic [2:0] c_alu_add = 3'b000;
   localparam logic [2:0] c_alu_sub = 3'b001;
   localparam logic [2:0] c_alu_inv = 3'b101;

   typedef enum logic [2:0] {
      ST_FETCH, ST_RD_A, ST_RD_B, ST_EXEC, ST_WB, ST_WF, ST_BR, ST_HALT
   } state_t;

   state_t          r_state;
   logic [PC_W-1:0] r_pc;
   logic [3:0]      r_op;
   logic [1:0]      r_rd;
   logic [7:0]      r_imm;
   logic [7:0]      r_a;
   logic [7:0]      r_b;
   logic            r_cy;
   logic            r_z;

   logic [3:0]      w_f_op;
   logic [1:0]      w_f_rd;
   logic [7:0]      w_f_imm;
   logic [PC_W-1:0] w_pc_inc;
   logic            w_taken;
   logic [1:0]      w_unused_ir;

   function automatic logic is_nop(input logic [3:0] op);
      return op[3:1] == 3'b011;
   endfunction

   function automatic logic is_incdec(input logic [3:0] op);
      return op[3:1] == 3'b101;
   endfunction

   function automatic logic is_cbr(input logic [3:0] op);
      return (op == c_op_jnz) || (op == c_op_jc) || (op == c_op_jz);
   endfunction

   // First-operand address: the flags register for JC/JZ, rd for INC/DEC/JNZ.
   function automatic logic [2:0] rd_a_addr(input logic [3:0] op, input logic [1:0] rd,
                                            input logic [1:0] rs1);
      if (op == c_op_jc || op == c_op_jz)      return FLAG_ADDR;
      else if (is_incdec(op) || op == c_op_jnz) return {1'b0, rd};
      else                                     return {1'b0, rs1};
   endfunction

   assign w_f_op      = bus.ir_data[15:12];
   assign w_f_rd      = bus.ir_data[9:8];
   assign w_f_imm     = bus.ir_data[7:0];
   assign w_unused_ir = bus.ir_data[11:10];
   assign w_pc_inc    = r_pc + PC_W'(1);
   assign bus.alu_a   = r_a;
   assign bus.alu_b   = r_b;

   always_comb begin
      w_taken = 1'b0;
      case (r_op)
         c_op_jmp: w_taken = 1'b1;
         c_op_jnz: w_taken = (r_a != 8'h00);
         c_op_jc:  w_taken = r_a[7];
         c_op_jz:  w_taken = r_a[6];
         default:  w_taken = 1'b0;
      endcase
   end

   // Outputs are registered: each transition loads the output values of the
   // state being entered, so async reset clears rf_wr immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= ST_FETCH;
         r_pc           <= '0;
         r_op           <= '0;
         r_rd           <= '0;
         r_imm          <= '0;
         r_a            <= '0;
         r_b            <= '0;
         r_cy           <= 1'b0;
         r_z            <= 1'b0;
         bus.pc_out     <= '0;
         bus.ir_en      <= 1'b0;
         bus.rf_addr    <= '0;
         bus.rf_rd      <= 1'b0;
         bus.rf_wr      <= 1'b0;
         bus.rf_din     <= '0;
         bus.alu_op     <= '0;
         bus.instr_done <= 1'b0;
         bus.halted     <= 1'b0;
      end else begin
         bus.pc_out     <= '0;
         bus.ir_en      <= 1'b0;
         bus.rf_addr    <= '0;
         bus.rf_rd      <= 1'b0;
         bus.rf_wr      <= 1'b0;
         bus.rf_din     <= '0;
         bus.alu_op     <= '0;
         bus.instr_done <= 1'b0;
         unique case (r_state)
            ST_FETCH: begin
               r_op  <= w_f_op;
               r_rd  <= w_f_rd;
               r_imm <= w_f_imm;
               if (w_f_op == c_op_load) begin
                  r_state        <= ST_WB;
                  bus.rf_wr      <= 1'b1;
                  bus.rf_addr    <= {1'b0, w_f_rd};
                  bus.rf_din     <= w_f_imm;
                  bus.instr_done <= 1'b1;
               end else if (is_nop(w_f_op) || w_f_op == c_op_jmp) begin
                  r_state        <= ST_BR;
                  bus.instr_done <= 1'b1;
               end else if (w_f_op == c_op_hlt) begin
                  r_state        <= ST_HALT;
                  bus.halted     <= 1'b1;
                  bus.instr_done <= 1'b1;
               end else begin
                  r_state     <= ST_RD_A;
                  bus.rf_rd   <= 1'b1;
                  bus.rf_addr <= rd_a_addr(w_f_op, w_f_rd, w_f_imm[5:4]);
               end
            end
            ST_RD_A: begin
               r_a <= bus.rf_dout;
               if (is_incdec(r_op)) begin
                  r_b        <= 8'd1;
                  r_state    <= ST_EXEC;
                  bus.alu_op <= r_op[0] ? c_alu_sub : c_alu_add;
               end else if (r_op == c_op_inv) begin
                  r_b        <= 8'd0;
                  r_state    <= ST_EXEC;
                  bus.alu_op <= c_alu_inv;
               end else if (is_cbr(r_op)) begin
                  r_state        <= ST_BR;
                  bus.instr_done <= 1'b1;
               end else begin
                  r_state     <= ST_RD_B;
                  bus.rf_rd   <= 1'b1;
                  bus.rf_addr <= {1'b0, r_imm[1:0]};
               end
            end
            ST_RD_B: begin
               r_b        <= bus.rf_dout;
               r_state    <= ST_EXEC;
               bus.alu_op <= r_op[2:0];
            end
            ST_EXEC: begin
               r_cy        <= bus.alu_cy;
               r_z         <= bus.alu_zero;
               r_state     <= ST_WB;
               bus.rf_wr   <= 1'b1;
               bus.rf_addr <= {1'b0, r_rd};
               bus.rf_din  <= bus.alu_out;
            end
            ST_WB: begin
               if (r_op == c_op_load) begin
                  r_pc       <= w_pc_inc;
                  r_state    <= ST_FETCH;
                  bus.ir_en  <= 1'b1;
                  bus.pc_out <= w_pc_inc;
               end else begin
                  r_state        <= ST_WF;
                  bus.rf_wr      <= 1'b1;
                  bus.rf_addr    <= FLAG_ADDR;
                  bus.rf_din     <= {r_cy, r_z, 6'b0};
                  bus.instr_done <= 1'b1;
               end
            end
            ST_WF: begin
               r_pc       <= w_pc_inc;
               r_state    <= ST_FETCH;
               bus.ir_en  <= 1'b1;
               bus.pc_out <= w_pc_inc;
            end
            ST_BR: begin
               r_pc       <= w_taken ? PC_W'(r_imm) : w_pc_inc;
               r_state    <= ST_FETCH;
               bus.ir_en  <= 1'b1;
               bus.pc_out <= w_taken ? PC_W'(r_imm) : w_pc_inc;
            end
            ST_HALT: begin
               bus.halted <= 1'b1;
            end
            default: r_state <= ST_FETCH;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_cpu_control_unit.sv
`default_nettype none
// ============================================================================
// tb_cpu_control_unit : program-level bench with memory, register file and ALU
// Revision 1.0 - initial release
// ============================================================================
module tb_cpu_control_unit;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic init_req = 1'b0;

   logic [15:0] mem [256];
   logic [7:0]  rf [8];
   logic [7:0]  rf_init [8];
   logic [8:0]  alu_t;

   int          ref_R [8];
   int          ref_pc;
   bit          ref_halted;
   logic [7:0]  fetch_log [$];
   int          n_vec = 0;
   int          n_fail = 0;

   cpu_control_unit_if #(.PC_W(8)) bus ();

   cpu_control_unit #(.PC_W(8), .FLAG_ADDR(3'b111)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   assign bus.ir_data = mem[bus.pc_out];
   assign bus.rf_dout = rf[bus.rf_addr];

   always @(posedge clk) begin
      if (init_req) rf <= rf_init;
      else if (bus.rf_wr) rf[bus.rf_addr] <= bus.rf_din;
   end

   always_comb begin
      case (bus.alu_op)
         3'b000:  alu_t = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
         3'b001:  alu_t = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
         3'b010:  alu_t = {1'b0, bus.alu_a & bus.alu_b};
         3'b011:  alu_t = {1'b0, bus.alu_a | bus.alu_b};
         3'b100:  alu_t = {1'b0, bus.alu_a ^ bus.alu_b};
         3'b101:  alu_t = {1'b0, ~bus.alu_a};
         default: alu_t = 9'd0;
      endcase
      bus.alu_out  = alu_t[7:0];
      bus.alu_cy   = alu_t[8];
      bus.alu_zero = (alu_t[7:0] == 8'h00);
   end

   // Instruction-level model: one call retires the instruction at ref_pc.
   // lat counts cycles from its FETCH to the instr_done pulse (HLT: HALT entry).
   task automatic ref_step(output int lat, output bit hlt);
      logic [15:0] w;
      int op, rd, rs1, rs2, imm, a, b, r, cy, nxt;
      bit alu;
      w = mem[ref_pc];
      op = int'(w[15:12]); rd = int'(w[9:8]); rs1 = int'(w[5:4]);
      rs2 = int'(w[1:0]); imm = int'(w[7:0]);
      a = ref_R[rs1]; b = ref_R[rs2];
      hlt = 0; alu = 0; r = 0; cy = 0; lat = 2; nxt = (ref_pc + 1) % 256;
      case (op)
         0:  begin r = (a + b) % 256; cy = (a + b > 255) ? 1 : 0; alu = 1; lat = 6; end
         1:  begin r = (a - b + 256) % 256; cy = (a < b) ? 1 : 0; alu = 1; lat = 6; end
         2:  begin r = a & b; alu = 1; lat = 6; end
         3:  begin r = a | b; alu = 1; lat = 6; end
         4:  begin r = a ^ b; alu = 1; lat = 6; end
         5:  begin r = 255 - a; alu = 1; lat = 5; end
         8:  ref_R[rd] = imm;
         10: begin a = ref_R[rd]; r = (a + 1) % 256; cy = (a == 255) ? 1 : 0; alu = 1; lat = 5; end
         11: begin a = ref_R[rd]; r = (a + 255) % 256; cy = (a == 0) ? 1 : 0; alu = 1; lat = 5; end
         15: nxt = imm;
         14: begin lat = 3; if (ref_R[rd] != 0) nxt = imm; end
         13: begin lat = 3; if (ref_R[7] >= 128) nxt = imm; end
         9:  begin lat = 3; if ((ref_R[7] / 64) % 2 == 1) nxt = imm; end
         12: begin hlt = 1; nxt = ref_pc; end
         default: ;
      endcase
      if (alu) begin
         ref_R[rd] = r;
         ref_R[7] = cy * 128 + ((r == 0) ? 64 : 0);
      end
      ref_pc = nxt;
      ref_halted = hlt;
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = 16'hC000;
   endtask

   // Random register contents, model reset, then release at posedge+1 (FETCH cycle).
   task automatic start();
      for (int i = 0; i < 8; i++) begin
         rf_init[i] = 8'($urandom);
         ref_R[i] = int'(rf_init[i]);
      end
      ref_pc = 0;
      ref_halted = 0;
      init_req = 1'b1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      init_req = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic run_program(input int max_retire, output int retired, output int wr_cnt);
      int cyc, budget, lat;
      bit pend, ended, stop, hlt;
      retired = 0; wr_cnt = 0; cyc = 1; budget = 0;
      pend = 0; ended = 0; stop = 0;
      fetch_log.delete();
      n_vec++;
      if (bus.pc_out !== 8'(ref_pc)) begin
         n_fail++;
         $display("FAIL fetch_pc: got %0h expected %0h", bus.pc_out, ref_pc);
      end
      fetch_log.push_back(bus.pc_out);
      while (!stop) begin
         @(posedge clk); #1;
         cyc++; budget++;
         if (pend) begin
            pend = 0;
            for (int i = 0; i < 8; i++) begin
               n_vec++;
               if (rf[i] !== 8'(ref_R[i])) begin
                  n_fail++;
                  $display("FAIL reg%0d after retire %0d: got %0h expected %0h", i, retired, rf[i], ref_R[i]);
               end
            end
            if (ref_halted) begin
               n_vec++;
               if (bus.halted !== 1'b1 || bus.instr_done !== 1'b0) begin
                  n_fail++;
                  $display("FAIL halt_hold: halted=%0b done=%0b expected 1/0", bus.halted, bus.instr_done);
               end
            end
            if (ended) stop = 1;
         end
         if (cyc == 1 && !ref_halted) begin
            n_vec++;
            if (bus.pc_out !== 8'(ref_pc)) begin
               n_fail++;
               $display("FAIL fetch_pc: got %0h expected %0h", bus.pc_out, ref_pc);
            end
            fetch_log.push_back(bus.pc_out);
         end
         if (!stop) begin
            if (bus.rf_wr) begin
               wr_cnt++;
               n_vec++;
               if (bus.rf_addr[2] !== 1'b0 && bus.rf_addr !== 3'b111) begin
                  n_fail++;
                  $display("FAIL wr_addr: got %0h expected 0-3 or 7", bus.rf_addr);
               end
            end
            if (bus.instr_done) begin
               ref_step(lat, hlt);
               n_vec++;
               if (cyc != lat) begin
                  n_fail++;
                  $display("FAIL latency retire %0d: got %0d expected %0d", retired, cyc, lat);
               end
               n_vec++;
               if (bus.halted !== hlt) begin
                  n_fail++;
                  $display("FAIL halted_flag: got %0b expected %0b", bus.halted, hlt);
               end
               retired++;
               cyc = 0;
               pend = 1;
               if (hlt || retired >= max_retire) ended = 1;
            end
         end
         if (budget >= 4000) begin
            n_vec++; n_fail++;
            $display("FAIL cycle_budget: got %0d retired expected halt", retired);
            stop = 1;
         end
      end
   endtask

   task automatic expect_val(input string name, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic load_add_program();
      clear_mem();
      mem[0] = 16'h8005; mem[1] = 16'h8103; mem[2] = 16'h0201; mem[3] = 16'hC000;
   endtask

   task automatic test_reset();
      load_add_program();
      start();
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      expect_val("reset_pc_out", int'(bus.pc_out), 0);
      expect_val("reset_strobes", int'({bus.ir_en, bus.rf_rd, bus.rf_wr, bus.instr_done, bus.halted}), 0);
      expect_val("reset_data", int'({bus.rf_addr, bus.rf_din, bus.alu_op}), 0);
   endtask

   task automatic test_add_program();
      int ret, wr, dones;
      load_add_program();
      start();
      run_program(100, ret, wr);
      expect_val("add_retired", ret, 4);
      expect_val("add_r0", int'(rf[0]), 8'h05);
      expect_val("add_r1", int'(rf[1]), 8'h03);
      expect_val("add_r2", int'(rf[2]), 8'h08);
      expect_val("add_flags", int'(rf[7]), 8'h00);
      dones = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         dones += int'(bus.instr_done) + (bus.halted ? 0 : 100);
      end
      expect_val("halt_stays", dones, 0);
   endtask

   task automatic test_jc_program();
      int ret, wr;
      clear_mem();
      mem[0] = 16'h80FF; mem[1] = 16'h8101; mem[2] = 16'h0201; mem[3] = 16'hD006;
      mem[4] = 16'h8207; mem[5] = 16'hC000; mem[6] = 16'hC000;
      start();
      run_program(100, ret, wr);
      expect_val("jc_r2", int'(rf[2]), 8'h00);
      expect_val("jc_flags", int'(rf[7]), 8'hC0);
      expect_val("jc_halt_pc", int'(fetch_log[fetch_log.size()-1]), 8'h06);
      expect_val("jc_halted", int'(bus.halted), 1);
   endtask

   task automatic test_dec_loop();
      int ret, wr;
      clear_mem();
      mem[0] = 16'h8003; mem[1] = 16'hB000; mem[2] = 16'hE001; mem[3] = 16'hC000;
      start();
      run_program(100, ret, wr);
      expect_val("dec_retired", ret, 8);
      expect_val("dec_r0", int'(rf[0]), 8'h00);
      expect_val("dec_flags", int'(rf[7]), 8'h40);
      expect_val("dec_halted", int'(bus.halted), 1);
   endtask

   task automatic test_jmp_wrap();
      int ret, wr;
      clear_mem();
      mem[0] = 16'hF0FF; mem[255] = 16'h6000;
      start();
      run_program(4, ret, wr);
      expect_val("wrap_fetch1", int'(fetch_log[1]), 8'hFF);
      expect_val("wrap_fetch2", int'(fetch_log[2]), 8'h00);
      expect_val("wrap_writes", wr, 0);
   endtask

   task automatic test_reset_mid_wb();
      int ret, wr;
      bit found;
      logic [7:0] r2_before;
      load_add_program();
      start();
      r2_before = rf_init[2];
      found = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (bus.rf_wr === 1'b1 && bus.rf_addr === 3'd2) begin
            found = 1;
            break;
         end
      end
      expect_val("mid_wb_reached", int'(found), 1);
      #2 rst_n = 1'b0;
      #1;
      expect_val("mid_rf_wr", int'(bus.rf_wr), 0);
      expect_val("mid_pc", int'(bus.pc_out), 0);
      expect_val("mid_halted", int'(bus.halted), 0);
      @(posedge clk); #1;
      expect_val("mid_r2_kept", int'(rf[2]), int'(r2_before));
      start();
      run_program(100, ret, wr);
      expect_val("mid_rerun_r2", int'(rf[2]), 8'h08);
   endtask

   task automatic test_nop();
      int ret, wr;
      clear_mem();
      mem[0] = 16'h7000;
      start();
      run_program(1, ret, wr);
      expect_val("nop_writes", wr, 0);
      expect_val("nop_retired", ret, 1);
      expect_val("nop_next_pc", int'(fetch_log[1]), 8'h01);
   endtask

   task automatic test_random();
      int ret, wr, op, n;
      logic [15:0] w;
      n = 12;
      for (int p = 0; p < 25; p++) begin
         clear_mem();
         for (int i = 0; i < n; i++) begin
            w = 16'($urandom);
            op = int'($urandom_range(0, 15));
            if (op == 12) op = 6;
            w[15:12] = 4'(op);
            if (op == 9 || op == 13 || op == 14 || op == 15)
               w[7:0] = 8'($urandom_range(i + 1, n));
            mem[i] = w;
         end
         start();
         run_program(200, ret, wr);
         expect_val("rand_halted", int'(bus.halted), 1);
      end
   endtask

   initial begin
      test_reset();
      test_add_program();
      test_jc_program();
      test_dec_loop();
      test_jmp_wrap();
      test_reset_mid_wb();
      test_nop();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
